// File: rtl/psdmuladd.sv
// Sequential multiply-accumulate: product = multiplicand * multiplier + addend,
// one multiplier bit per cycle (inverse of the sequential divider).
module psdmuladd (
    input  logic        clock,
    input  logic        reset,
    input  logic        run,
    output logic        busy,
    output logic        done,
    input  logic [31:0] multiplicand,
    input  logic [15:0] multiplier,
    input  logic [15:0] addend,
    output logic [47:0] product,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        LOAD = 2'd2
    } state_t;

    state_t      state, state_next;
    logic [47:0] mcand_r;
    logic [15:0] mplier_r;
    logic [47:0] acc;
    logic [3:0]  cnt;

    assign dbg_state = state;

    // Handshake: run is sampled only in IDLE; busy is high from the accepting
    // edge through the LOAD edge, where done pulses once with product updated.
    // A run seen while busy is dropped, never queued.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (run) state_next = CALC;
            CALC:    if (cnt == 4'd15) state_next = LOAD;
            LOAD:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            product  <= 48'd0;
            mcand_r  <= 48'd0;
            mplier_r <= 16'd0;
            acc      <= 48'd0;
            cnt      <= 4'd0;
        end else begin
            state <= state_next;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (run) begin
                        mcand_r  <= {16'd0, multiplicand};
                        mplier_r <= multiplier;
                        acc      <= {32'd0, addend};
                        cnt      <= 4'd0;
                        busy     <= 1'b1;
                    end
                end
                CALC: begin
                    // Fixed 16 iterations; no early exit when the multiplier runs out of ones.
                    if (mplier_r[0]) acc <= acc + mcand_r;
                    mcand_r  <= mcand_r << 1;
                    mplier_r <= mplier_r >> 1;
                    cnt      <= cnt + 4'd1;
                end
                LOAD: begin
                    product <= acc;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_psdmuladd.sv
// Bench for psdmuladd: directed operations, expected products queued at issue
// and checked by an independent monitor whenever done pulses.
module tb_psdmuladd;

    logic        clock;
    logic        reset;
    logic        run;
    logic        busy;
    logic        done;
    logic [31:0] multiplicand;
    logic [15:0] multiplier;
    logic [15:0] addend;
    logic [47:0] product;
    logic [1:0]  dbg_state;

    logic [47:0] exp_q[$];
    int checks;
    int errors;
    int done_total;
    int exp_done;

    psdmuladd dut (
        .clock        (clock),
        .reset        (reset),
        .run          (run),
        .busy         (busy),
        .done         (done),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .addend       (addend),
        .product      (product),
        .dbg_state    (dbg_state)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached (errors=%0d)", errors);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // scoreboard monitor
    always @(negedge clock) begin
        if (!reset && done) begin
            done_total++;
            check("done_busy_low", {47'd0, busy}, 48'd0);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got product 0x%0h, expected no done", product);
            end else begin
                check("product", product, exp_q.pop_front());
            end
        end
    end

    // driver tasks: called at a negedge, return at a negedge
    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 40) begin
            n++;
            @(negedge clock);
        end
    endtask

    task automatic do_run(input logic [31:0] a, input logic [15:0] b, input logic [15:0] c,
                          input logic [47:0] exp_p, input string name);
        int n;
        multiplicand = a;
        multiplier   = b;
        addend       = c;
        run          = 1'b1;
        exp_q.push_back(exp_p);
        exp_done++;
        @(posedge clock);
        @(negedge clock);
        run = 1'b0;
        multiplicand = $urandom;
        multiplier   = 16'($urandom);
        addend       = 16'($urandom);
        wait_idle(n);
        check({name, "_busy_cycles"}, 48'(n), 48'd17);
    endtask

    initial begin
        int n;
        checks = 0; errors = 0; done_total = 0; exp_done = 0;
        reset = 1'b1; run = 1'b0;
        multiplicand = '0; multiplier = '0; addend = '0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("reset_busy", {47'd0, busy}, 48'd0);
        check("reset_done", {47'd0, done}, 48'd0);
        check("reset_product", product, 48'd0);

        do_run(32'd7, 16'd3, 16'd1, 48'd22, "basic");
        do_run(32'd142857, 16'd7, 16'd1, 48'd1000000, "reconstruct");
        do_run(32'hFFFF_FFFF, 16'hFFFF, 16'hFFFF, 48'hFFFF_0000_0000, "max");
        do_run(32'h1234_5678, 16'd0, 16'hABCD, 48'h0000_0000_ABCD, "zero_mult");

        // run and operand changes during CALC must be ignored
        multiplicand = 32'd5; multiplier = 16'd5; addend = 16'd0;
        run = 1'b1;
        exp_q.push_back(48'd25);
        exp_done++;
        @(posedge clock);
        @(negedge clock);
        run = 1'b0;
        repeat (3) @(negedge clock);
        multiplicand = 32'd9; multiplier = 16'd9; addend = 16'd0;
        run = 1'b1;
        @(negedge clock);
        run = 1'b0;
        multiplicand = 32'hDEAD_BEEF; multiplier = 16'h1357; addend = 16'h2468;
        wait_idle(n);
        check("overlap_busy_cycles", 48'(n + 4), 48'd17);
        do_run(32'd9, 16'd9, 16'd0, 48'd81, "back_to_back");

        // reset mid-operation abandons the run
        do_run(32'd7, 16'd3, 16'd1, 48'd22, "pre_reset");
        check("pre_reset_product", product, 48'd22);
        multiplicand = 32'd100; multiplier = 16'd100; addend = 16'd1;
        run = 1'b1;
        @(posedge clock);
        @(negedge clock);
        run = 1'b0;
        repeat (7) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("midreset_busy", {47'd0, busy}, 48'd0);
        check("midreset_product", product, 48'd0);
        check("midreset_done", {47'd0, done}, 48'd0);
        repeat (20) @(negedge clock);
        check("midreset_no_done", 48'(done_total), 48'(exp_done));
        do_run(32'd2, 16'd2, 16'd2, 48'd6, "after_reset");

        repeat (3) @(negedge clock);
        check("done_count", 48'(done_total), 48'(exp_done));
        check("queue_empty", 48'(exp_q.size()), 48'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
